hazard_scoreboard_unit: RTL

//  Next-generation hazard unit for the 5-stage pipeline. Keeps the E/D forwarding, load-use and

---
 rtl/hazard_scoreboard_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Brief    : Hazard unit for the 5-stage pipeline. Covers E/D forwarding,
//            load-use and branch-compare stalls, a per-register pending-write
//            scoreboard for variable-latency long ops, and a limit on how many
//            long ops may be in flight. Drives the F/D stall and E flush.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_branch_d,
    input  logic              sig_long_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              sig_reg_write_e,
    input  logic              sig_reg_write_m,
    input  logic              sig_reg_write_w,
    input  logic              sig_mem_to_reg_e,
    input  logic              sig_mem_to_reg_m,
    input  logic              long_issue_e,
    input  logic              long_done_w,
    input  logic [REG_AW-1:0] long_dest_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              forward_a_d,
    output logic              forward_b_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_count,
    output logic [REG_AW:0]   long_busy
);

    localparam int              c_nreg     = 2 ** REG_AW;
    localparam logic [REG_AW:0] c_max_long = (REG_AW + 1)'(MAX_LONG);
    localparam logic [REG_AW:0] c_lb_one   = (REG_AW + 1)'(1);
    localparam logic [CNT_W-1:0] c_sc_one  = CNT_W'(1);
    localparam logic [c_nreg-1:0] c_bit0   = c_nreg'(1);

    logic [c_nreg-1:0] r_busy;
    logic [REG_AW:0]   r_long_busy;
    logic [CNT_W-1:0]  r_stall_count;

    logic [c_nreg-1:0] w_set_mask;
    logic [c_nreg-1:0] w_clr_mask;
    logic [c_nreg-1:0] w_busy_eff;
    logic              w_lwstall;
    logic              w_brstall;
    logic              w_sbstall;
    logic              w_limstall;
    logic              w_stall;
    logic              w_fwd_a_d;
    logic              w_fwd_b_d;
    logic [1:0]        w_fwd_a_e;
    logic [1:0]        w_fwd_b_e;
    logic [REG_AW:0]   w_long_busy_nxt;

    // Scoreboard masks; the W-stage clear is visible to D in the same cycle
    // because the register file writes in the first half-cycle.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (long_issue_e && (write_reg_e != '0))
            w_set_mask = c_bit0 << write_reg_e;
        if (long_done_w)
            w_clr_mask = c_bit0 << long_dest_w;
        w_busy_eff = r_busy & ~w_clr_mask;
    end

    // Forwarding muxes; register 0 never matches, M beats W.
    always_comb begin
        w_fwd_a_d = sig_reg_write_m && (rs_d != '0) && (rs_d == write_reg_m);
        w_fwd_b_d = sig_reg_write_m && (rt_d != '0) && (rt_d == write_reg_m);
        w_fwd_a_e = 2'b00;
        w_fwd_b_e = 2'b00;
        if (sig_reg_write_m && (rs_e != '0) && (rs_e == write_reg_m))
            w_fwd_a_e = 2'b10;
        else if (sig_reg_write_w && (rs_e != '0) && (rs_e == write_reg_w))
            w_fwd_a_e = 2'b01;
        if (sig_reg_write_m && (rt_e != '0) && (rt_e == write_reg_m))
            w_fwd_b_e = 2'b10;
        else if (sig_reg_write_w && (rt_e != '0) && (rt_e == write_reg_w))
            w_fwd_b_e = 2'b01;
    end

    // Stall sources; rt_d doubles as the D destination for the WAW check.
    always_comb begin
        w_lwstall  = sig_mem_to_reg_e && (write_reg_e != '0) &&
                     ((rs_d == write_reg_e) || (rt_d == write_reg_e));
        w_brstall  = sig_branch_d &&
                     ((sig_reg_write_e && (write_reg_e != '0) &&
                       ((rs_d == write_reg_e) || (rt_d == write_reg_e))) ||
                      (sig_mem_to_reg_m && (write_reg_m != '0) &&
                       ((rs_d == write_reg_m) || (rt_d == write_reg_m))));
        w_sbstall  = w_busy_eff[rs_d] || w_busy_eff[rt_d];
        w_limstall = sig_long_d && (r_long_busy == c_max_long) && !long_done_w;
        w_stall    = w_lwstall || w_brstall || w_sbstall || w_limstall;
    end

    // In-flight counter: issue and done together leave it unchanged, and an
    // overflow/underflow holds the count.
    always_comb begin
        w_long_busy_nxt = r_long_busy;
        if (long_issue_e && !long_done_w && (r_long_busy != c_max_long))
            w_long_busy_nxt = r_long_busy + c_lb_one;
        else if (long_done_w && !long_issue_e && (r_long_busy != '0))
            w_long_busy_nxt = r_long_busy - c_lb_one;
    end

    // Scoreboard state; clear before set so issue+done on one register leaves it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_long_busy <= '0;
        end else begin
            r_busy      <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_long_busy <= w_long_busy_nxt;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_count <= '0;
        else if (w_stall && !(&r_stall_count))
            r_stall_count <= r_stall_count + c_sc_one;
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_f     = w_stall & rst_n;
    assign stall_d     = w_stall & rst_n;
    assign flush_e     = w_stall & rst_n;
    assign forward_a_d = w_fwd_a_d & rst_n;
    assign forward_b_d = w_fwd_b_d & rst_n;
    assign forward_a_e = w_fwd_a_e & {2{rst_n}};
    assign forward_b_e = w_fwd_b_e & {2{rst_n}};
    assign stall_count = r_stall_count;
    assign long_busy   = r_long_busy;

    // Protocol checks on the in-flight counter.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(long_issue_e && !long_done_w && (r_long_busy == c_max_long)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(long_done_w && !long_issue_e && (r_long_busy == '0)));

endmodule
`default_nettype wire
